// File: rtl/rhd_emu_pkg.sv
// Shared constants, types and ROM contents for the RHD2164 chip emulator.
package rhd_emu_pkg;

    localparam int unsigned WORD_BITS = 16;

    // Opcode field, command bits 15:14.
    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_MISC    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [WORD_BITS-1:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [WORD_BITS-1:0] CMD_CLEAR     = 16'h6A00;

    // Registers 0..17 are RAM; everything above is ROM or reads as zero.
    localparam logic [5:0] REG_LAST_WRITABLE = 6'd17;
    localparam int unsigned NUM_REGS = 18;

    localparam logic [5:0] ADDR_INTAN_I  = 6'd40;
    localparam logic [5:0] ADDR_INTAN_N1 = 6'd41;
    localparam logic [5:0] ADDR_INTAN_T  = 6'd42;
    localparam logic [5:0] ADDR_INTAN_A  = 6'd43;
    localparam logic [5:0] ADDR_INTAN_N2 = 6'd44;
    localparam logic [5:0] ADDR_MISO_MRK = 6'd59;
    localparam logic [5:0] ADDR_DIE_REV  = 6'd60;
    localparam logic [5:0] ADDR_UNIPOLAR = 6'd61;
    localparam logic [5:0] ADDR_NUM_AMPS = 6'd62;
    localparam logic [5:0] ADDR_CHIP_ID  = 6'd63;

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    // One response word pair: A goes out on SCLK falls, B on SCLK rises.
    typedef struct packed {
        logic [WORD_BITS-1:0] a;
        logic [WORD_BITS-1:0] b;
    } resp_t;

    // ROM lookup: returns {A byte, B byte}; unknown addresses read zero.
    function automatic logic [15:0] rom_read(input logic [5:0] addr, input logic [7:0] chip_id);
        logic [15:0] ab;
        case (addr)
            ADDR_INTAN_I:  ab = 16'h4949;
            ADDR_INTAN_N1: ab = 16'h4E4E;
            ADDR_INTAN_T:  ab = 16'h5454;
            ADDR_INTAN_A:  ab = 16'h4141;
            ADDR_INTAN_N2: ab = 16'h4E4E;
            ADDR_MISO_MRK: ab = 16'h353A;
            ADDR_DIE_REV:  ab = 16'h0101;
            ADDR_UNIPOLAR: ab = 16'h0101;
            ADDR_NUM_AMPS: ab = 16'h4040;
            ADDR_CHIP_ID:  ab = {chip_id, chip_id};
            default:       ab = 16'h0000;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/rhd_spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
module rhd_spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to 0 means a pin already low at reset release never shows a fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/rhd_chip_emulator.sv
// SPI responder emulating one RHD2164: command decode, register file and DDR MISO.
module rhd_chip_emulator
    import rhd_emu_pkg::*;
#(
    parameter logic [15:0] STARTING_SEED = 16'd0,
    parameter logic [7:0]  CHIP_ID       = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic [15:0] frame_count,
    output logic        bad_frame
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_meta, mosi_sync;

    rhd_spi_sync_edge u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    rhd_spi_sync_edge u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (CS),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // MOSI needs only the level, aligned with the SCLK synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    state_e state_q, state_d;
    logic   start, shifting, frame_end;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next state: a frame opens on CS fall and closes on CS rise.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StShift;
            StShift: if (cs_rise) state_d = StIdle;
        endcase
    end

    // FSM strobes consumed by the datapath.
    always_comb begin
        start     = (state_q == StIdle) && cs_fall;
        shifting  = (state_q == StShift);
        frame_end = (state_q == StShift) && cs_rise;
    end

    logic [WORD_BITS-1:0] shift_q, shift_next;
    logic [4:0]           bit_cnt_q, cnt_next;
    logic                 do_shift, frame_ok;
    logic [3:0]           a_idx, b_idx;
    resp_t                stage1_q, stage2_q, resp_new;
    logic [7:0]           regs [0:NUM_REGS-1];

    // Next shift/count include an SCLK rise landing in the same cycle as CS rise.
    assign do_shift   = shifting && sclk_rise && (bit_cnt_q < 5'd16);
    assign shift_next = do_shift ? {shift_q[WORD_BITS-2:0], mosi_sync} : shift_q;
    assign cnt_next   = do_shift ? bit_cnt_q + 5'd1 : bit_cnt_q;
    assign frame_ok   = frame_end && (cnt_next == 5'd16);
    assign a_idx      = 4'd15 - bit_cnt_q[3:0];
    assign b_idx      = 4'd0 - cnt_next[3:0];

    logic [1:0]  cmd_op;
    logic [5:0]  cmd_reg;
    logic [4:0]  cmd_chan;
    logic [7:0]  cmd_data;
    logic [15:0] conv_a, rom_ab;
    logic        wr_en, fc_clear, fc_inc;

    assign cmd_op   = shift_next[15:14];
    assign cmd_reg  = shift_next[13:8];
    assign cmd_chan = shift_next[12:8];
    assign cmd_data = shift_next[7:0];

    // Response and side effects of the command completing this cycle.
    always_comb begin
        resp_new = '0;
        wr_en    = 1'b0;
        fc_clear = 1'b0;
        fc_inc   = 1'b0;
        rom_ab   = rom_read(cmd_reg, CHIP_ID);
        conv_a   = STARTING_SEED + {11'd0, cmd_chan} + {frame_count[9:0], 6'd0};
        unique case (cmd_op)
            OP_CONVERT: begin
                resp_new.a = conv_a;
                resp_new.b = conv_a + 16'd32;
                fc_inc     = (cmd_chan == 5'd31);
            end
            OP_MISC: begin
                if (shift_next == CMD_CALIBRATE) begin
                    resp_new.a = 16'h8000;
                    resp_new.b = 16'h8000;
                end
                fc_clear = (shift_next == CMD_CLEAR);
            end
            OP_WRITE: begin
                resp_new.a = {8'hFF, cmd_data};
                resp_new.b = {8'hFF, cmd_data};
                wr_en      = (cmd_reg <= REG_LAST_WRITABLE);
            end
            OP_READ: begin
                if (cmd_reg <= REG_LAST_WRITABLE) begin
                    resp_new.a = {8'h00, regs[cmd_reg[4:0]]};
                    resp_new.b = {8'h00, regs[cmd_reg[4:0]]};
                end else begin
                    resp_new.a = {8'h00, rom_ab[15:8]};
                    resp_new.b = {8'h00, rom_ab[7:0]};
                end
            end
        endcase
    end

    // Register file; a write commits at CS rise so the very next READ sees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (frame_ok && wr_en) begin
            regs[cmd_reg[4:0]] <= cmd_data;
        end
    end

    // Shifter, MISO driver, two-stage response pipeline and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            MISO        <= 1'b0;
            cmd_valid   <= 1'b0;
            bad_frame   <= 1'b0;
            cmd_word    <= '0;
            frame_count <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
        end else begin
            cmd_valid <= 1'b0;
            bad_frame <= 1'b0;
            if (start) begin
                shift_q   <= '0;
                bit_cnt_q <= '0;
                MISO      <= stage2_q.a[15];
            end
            if (shifting) begin
                shift_q   <= shift_next;
                bit_cnt_q <= cnt_next;
                if (do_shift) begin
                    MISO <= stage2_q.b[b_idx];
                end else if (sclk_fall && (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd16)) begin
                    MISO <= stage2_q.a[a_idx];
                end
            end
            if (frame_end) begin
                MISO <= 1'b0;
                if (frame_ok) begin
                    cmd_valid <= 1'b1;
                    cmd_word  <= shift_next;
                    stage1_q  <= resp_new;
                    stage2_q  <= stage1_q;
                    if (fc_clear)    frame_count <= '0;
                    else if (fc_inc) frame_count <= frame_count + 16'd1;
                end else begin
                    bad_frame <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rhd_chip_emulator.sv
// Directed bench for rhd_chip_emulator: drives SPI frames and captures DDR MISO.
module tb_rhd_chip_emulator;

    logic        clk = 1'b0;
    logic        rst, sclk, cs, mosi;
    logic        miso, cmd_valid, bad_frame;
    logic [15:0] cmd_word, frame_count;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int bad_cnt   = 0;
    int vc0, bc0;
    logic [15:0] a, b, ea;

    rhd_chip_emulator #(
        .STARTING_SEED (16'd0),
        .CHIP_ID       (8'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (sclk),
        .CS          (cs),
        .MOSI        (mosi),
        .MISO        (miso),
        .cmd_valid   (cmd_valid),
        .cmd_word    (cmd_word),
        .frame_count (frame_count),
        .bad_frame   (bad_frame)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_valid) valid_cnt++;
        if (bad_frame) bad_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clock nbits of cmd; capture A on the SCLK-low phases and B on the high phases.
    task automatic spi_bits(input logic [15:0] cmd, input int nbits, input int half,
                            input bit raise_cs, output logic [15:0] ra, output logic [15:0] rb);
        ra = '0;
        rb = '0;
        cs = 1'b0;
        sclk = 1'b0;
        mosi = cmd[15];
        tick(half);
        ra[15] = miso;
        for (int j = 1; j <= nbits; j++) begin
            sclk = 1'b1;
            tick(half);
            rb[16-j] = miso;
            sclk = 1'b0;
            if (j < 16) mosi = cmd[15-j];
            tick(half);
            if (j < 16) ra[15-j] = miso;
        end
        if (raise_cs) begin
            cs = 1'b1;
            mosi = 1'b0;
            tick(half + 6);
        end
    endtask

    task automatic frame(input logic [15:0] cmd, input int half,
                         output logic [15:0] ra, output logic [15:0] rb);
        spi_bits(cmd, 16, half, 1'b1, ra, rb);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(4);
        check("rst_miso", {15'd0, miso}, 16'd0);
        check("rst_cmd_valid", {15'd0, cmd_valid}, 16'd0);
        check("rst_bad_frame", {15'd0, bad_frame}, 16'd0);
        check("rst_cmd_word", cmd_word, 16'h0000);
        check("rst_frame_count", frame_count, 16'h0000);

        // ROM reads: third frame carries the first response.
        frame(16'hE800, 4, a, b);
        check("rom_f1_a", a, 16'h0000);
        check("rom_f1_b", b, 16'h0000);
        frame(16'hE900, 4, a, b);
        check("rom_f2_a", a, 16'h0000);
        frame(16'hEA00, 4, a, b);
        check("rom_f3_a", a, 16'h0049);
        check("rom_f3_b", b, 16'h0049);
        check("rom_cmd_word", cmd_word, 16'hEA00);
        check("rom_valid_cnt", valid_cnt[15:0], 16'd3);

        // WRITE reg 5 then READ it back.
        frame(16'h85A5, 4, a, b);
        check("wr_f1_a", a, 16'h004E);
        frame(16'hC500, 4, a, b);
        check("wr_f2_a", a, 16'h0054);
        frame(16'hE800, 4, a, b);
        check("wr_f3_a", a, 16'hFFA5);
        check("wr_f3_b", b, 16'hFFA5);
        frame(16'hE800, 4, a, b);
        check("wr_f4_a", a, 16'h00A5);
        check("wr_f4_b", b, 16'h00A5);

        // Two CONVERT sweeps (second with the ignored bit 13 set), then two dummies.
        for (int i = 0; i < 66; i++) begin
            if (i < 32)      frame({3'b000, 5'(i), 8'h00}, 4, a, b);
            else if (i < 64) frame({3'b001, 5'(i - 32), 8'h00}, 4, a, b);
            else             frame(16'hE800, 4, a, b);
            if (i < 2) begin
                check("conv_prime_a", a, 16'h0049);
            end else begin
                ea = 16'((((i - 2) / 32) * 64) + ((i - 2) % 32));
                check("conv_a", a, ea);
                check("conv_b", b, ea + 16'd32);
            end
        end
        check("conv_frame_count", frame_count, 16'd2);
        frame(16'h6A00, 4, a, b);
        check("clear_frame_count", frame_count, 16'd0);

        // CALIBRATE and the A/B marker register at two SCLK rates.
        frame(16'h5500, 4, a, b);
        frame(16'hFB00, 4, a, b);
        check("clear_resp_a", a, 16'h0000);
        frame(16'hFB00, 8, a, b);
        check("cal_a", a, 16'h8000);
        check("cal_b", b, 16'h8000);
        frame(16'hE800, 4, a, b);
        check("r59_div8_a", a, 16'h0035);
        check("r59_div8_b", b, 16'h003A);
        frame(16'hE800, 8, a, b);
        check("r59_div16_a", a, 16'h0035);
        check("r59_div16_b", b, 16'h003A);

        // Short frame must not advance the pipeline.
        frame(16'hFE00, 4, a, b);
        frame(16'hFF00, 4, a, b);
        vc0 = valid_cnt;
        bc0 = bad_cnt;
        spi_bits(16'hFC00, 10, 4, 1'b1, a, b);
        check("short_bad_cnt", 16'(bad_cnt - bc0), 16'd1);
        check("short_valid_cnt", 16'(valid_cnt - vc0), 16'd0);
        check("short_cmd_word", cmd_word, 16'hFF00);
        frame(16'hE800, 4, a, b);
        check("post_short_a", a, 16'h0040);
        frame(16'hE800, 4, a, b);
        check("post_short_b", b, 16'h0004);

        // CONVERT 31 bumps frame_count, then reset aborts a half-sent READ 63.
        frame(16'h1F00, 4, a, b);
        check("c31_frame_count", frame_count, 16'd1);
        bc0 = bad_cnt;
        spi_bits(16'hFF00, 8, 4, 1'b0, a, b);
        rst = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        check("mid_rst_miso", {15'd0, miso}, 16'd0);
        check("mid_rst_cmd_word", cmd_word, 16'h0000);
        check("mid_rst_frame_count", frame_count, 16'h0000);
        cs = 1'b1;
        tick(10);
        check("mid_rst_no_bad", 16'(bad_cnt - bc0), 16'd0);
        frame(16'hFF00, 4, a, b);
        check("mid_rst_f1_a", a, 16'h0000);
        frame(16'hE800, 4, a, b);
        check("mid_rst_f2_a", a, 16'h0000);
        frame(16'hE900, 4, a, b);
        check("mid_rst_f3_a", a, 16'h0004);
        check("mid_rst_f3_b", b, 16'h0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rhd_chip_emulator.md
Name: rhd_chip_emulator

Overview:
- Synthesizable emulator of one RHD2164 amplifier chip: the SPI responder for the rhd_2048 controller.
- Oversamples SCLK/CS/MOSI on the system clock and decodes the 16-bit RHD commands: CONVERT, CALIBRATE, CLEAR, WRITE, READ.
- Returns deterministic DDR MISO data with the chip's two-command pipeline latency.
- Used for hardware-in-the-loop bring-up of the recording path without headstages.

Parameters:
- STARTING_SEED, 0: base value added to every CONVERT sample.
- CHIP_ID, 4: value of ROM register 63 (4 = RHD2164).

Ports:
- clk  in  1  system clock; must be >= 8x SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock from the controller, asynchronous to clk, idle low (mode 0).
- CS  in  1  chip select, active low, asynchronous.
- MOSI  in  1  command data, MSB first, asynchronous.
- MISO  out  1  DDR response line.
- cmd_valid  out  1  one-cycle pulse when a complete 16-bit command is accepted.
- cmd_word  out  16  last accepted command; held until the next cmd_valid.
- frame_count  out  16  number of completed CONVERT(31) commands since reset or CLEAR.
- bad_frame  out  1  one-cycle pulse when CS rises after fewer than 16 SCLK rising edges.

Behaviour:
- Input sync: SCLK, CS and MOSI each pass through 2 flops. Edges are detected on the synchronized copies.
- Pin-to-action latency: 3 clk cycles from a pin edge to the internal action or MISO update.
- Reset values: MISO=0, cmd_valid=0, cmd_word=0, bad_frame=0, frame_count=0, bit counter=0. Response pipeline stages are 0x0000 on both A and B. Registers 0-17 are 0.
- State machine:
  - IDLE: go to SHIFT on synced CS falling edge.
  - SHIFT: on each synced SCLK rise, shift MOSI in and increment the bit counter.
  - On synced CS rise in SHIFT:
    - count==16: pulse cmd_valid, execute the command, advance the pipeline, go to IDLE.
    - count<16: pulse bad_frame, discard the command, do not advance the pipeline, go to IDLE.
  - SCLK rises beyond 16 are ignored; the counter saturates at 16.
- Pipeline: the response to command n is transmitted during command n+2. The two stages are 16-bit A/B word pairs.
- Command decode (bits 15:14):
  - 00 CONVERT channel C=cmd[12:8] (cmd[13] ignored).
    - A = STARTING_SEED + C + 64*frame_count.
    - B = A + 32.
    - Arithmetic is 16-bit and wraps.
    - If C==31, frame_count increments after the sample is computed.
  - 01 with cmd==0x5500 CALIBRATE: A=B=0x8000.
  - 01 with cmd==0x6A00 CLEAR: A=B=0x0000 and frame_count is cleared to 0.
  - 01 with any other value: A=B=0x0000, no side effect.
  - 10 WRITE reg R=cmd[13:8], data D=cmd[7:0]: A=B={0xFF,D}. The write takes effect only for R<=17; other addresses are left unchanged.
  - 11 READ reg R: A=B={0x00,value}.
    - R<=17: the stored value.
    - 40-44: 'I','N','T','A','N'.
    - 59: A=0x35, B=0x3A.
    - 60: 0x01.
    - 61: 0x01.
    - 62: 0x40.
    - 63: CHIP_ID.
    - All others: 0.
- A WRITE followed by a READ of the same register in the next command returns the new value, since the write commits at CS rise.
- MISO DDR:
  - A[15] is driven on CS fall.
  - A[15-k] after the k-th SCLK fall.
  - B[15-k] after the (k+1)-th SCLK rise.
  - MISO is 0 while CS is high.
- Simultaneous events: a CS rise and the 16th SCLK rise in the same clk cycle count as a complete frame. A CS fall while already in SHIFT is impossible by construction.
- Reset mid-frame: the frame is aborted, no bad_frame pulse is issued, and all state returns to reset values.

Decomposition:
- Package rhd_emu_pkg:
  - opcode field constants (CONVERT/WRITE/READ, CALIBRATE=0x5500, CLEAR=0x6A00);
  - ROM register addresses and values (40-44, 59-63);
  - the writable register limit (17);
  - WORD_BITS=16.
- One sub-module, rhd_spi_sync_edge: 2-flop synchronizer plus rise/fall detect, instantiated for SCLK and CS. MOSI uses the synchronizer only.

Test Plan:
- Reset, then READ 40, READ 41, READ 42 -> third frame MISO A/B word = 0x0049 ('I'). The first two frames return 0x0000. cmd_word=0xEA00 after the last frame.
- WRITE reg 5 = 0xA5, READ 5, dummy READ 40, dummy READ 40 -> A=B=0xFFA5 in frame 3, 0x00A5 in frame 4.
- STARTING_SEED=0: CONVERT 0..31 twice, then 2 dummies -> first pass A=C, B=C+32; second pass A=64+C, B=96+C; frame_count=2. A following CLEAR sets frame_count=0.
- READ 59 then 2 dummies -> DDR capture gives A=0x0035, B=0x003A. Check bit timing with SCLK = clk/8 and clk/16.
- CS pulsed low for 10 SCLK cycles -> bad_frame pulse, no cmd_valid. The next full frame's response is unshifted (pipeline not advanced).
- rst asserted after 8 bits of a READ 63 -> MISO=0 and outputs at reset values. The next three frames return 0x0000, 0x0000, then the correct first response.
